reduce_nway_pipe: RTL
=====================

Name: reduce_nway_pipe

Overview:
- Parametrised, pipelined N-input reduction unit: the next generation of the 8-way OR tree.
- Generalised in three ways: width is a parameter, the operation is selectable per beat (OR/AND/XOR), and the tree is registered at a configurable interval.
- Valid/ready handshake lets it sit between the decode/ALU datapath and any consumer that can stall.
- Used for zero/any/parity flags on wide buses.

Parameters:
- WIDTH, 8, number of input bits reduced; legal range 2..64.
- REG_EVERY, 1, register after every REG_EVERY tree levels; legal range 1..clog2(WIDTH).
- LATENCY (localparam), derived: ceil(clog2(WIDTH)/REG_EVERY) cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active high.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- in_data  in  WIDTH  bits to reduce.
- in_mode  in  2  00 = OR, 01 = AND, 10 = XOR, 11 = OR (reserved, treated as OR).
- in_last  in  1  end-of-frame marker; exists only when REDUCE_ACCUM_EN is defined.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_bit  out  1  reduction result.

Behaviour:
- One clock; reset is synchronous and active-high.
  - On a reset cycle, all stage valid bits clear, out_valid = 0, out_bit = 0, and the accumulator clears.
  - In-flight beats are discarded.
  - in_ready = 1 in the cycle after reset is released.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - When advance = 0, every pipeline register, including each stage's valid and mode bits, holds.
  - While stalled, out_bit and out_valid remain stable.
- Tree:
  - Balanced binary tree of clog2(WIDTH) levels.
  - If WIDTH is not a power of two, inputs are padded to 2^clog2(WIDTH) with the identity element: 0 for OR and XOR, 1 for AND.
  - in_mode is captured with the beat and carried down the pipeline alongside the data, so consecutive beats may use different modes.
- Latency and throughput:
  - An accepted beat appears on out_valid/out_bit exactly LATENCY cycles later, provided no stall occurs; each stall cycle adds one.
  - Throughput is one beat per cycle.
  - Order is preserved; there is no bubble collapsing requirement beyond the global stall.
- Each stage register consists of a valid bit, a mode (2 bits) and partial results.
  - A stage with valid = 0 may carry arbitrary data.
  - out_bit is meaningful only while out_valid = 1; while out_valid = 0 it holds its last value.
- Simultaneous in_valid and a stall: the beat is not accepted, and the producer must hold it.
- Reset takes priority over all handshake activity in the same cycle.

Optional Feature:
- Macro REDUCE_ACCUM_EN.
- When defined:
  - The in_last port exists, and frames of multiple beats are reduced into one result.
  - The mode is taken from the first beat of a frame; later beats' in_mode is ignored.
  - At the output stage, a stage-valid beat with first-of-frame set loads the accumulator with its partial result. Otherwise the accumulator combines with it using the frame mode.
  - out_valid asserts only for the beat carrying last, with out_bit = the combined value. Latency is still LATENCY, and non-last beats produce no output.
  - The first-of-frame flag sets on reset and after each last beat.
- When undefined:
  - No in_last port and no accumulator; every beat produces one output.

Test Plan:
- WIDTH=8, REG_EVERY=1, OR: in_data 8'h00 then 8'h10 back-to-back -> out_valid on cycles 3 and 4 after the first accept, with out_bit 0 then 1.
- AND 8'hFF, AND 8'hFE, XOR 8'h07, XOR 8'h0F on consecutive cycles -> out_bit sequence 1, 0, 1, 0, one result per cycle.
- Stream 4 beats with out_ready held low for 5 cycles once out_valid rises -> in_ready = 0, out_bit stable, no beat lost or reordered after out_ready returns.
- 3 beats in flight, reset pulsed for 1 cycle -> out_valid = 0 the next cycle, and none of the 3 results ever appear.
- WIDTH=5, REG_EVERY=2: AND 5'h1F -> 1, XOR 5'h10 -> 1, OR 5'h00 -> 0; latency = 2.
- REDUCE_ACCUM_EN, OR frame 8'h00, 8'h00, 8'h04 with in_last on the third beat, then an AND frame {8'hFF, 8'h7F} -> exactly two outputs, out_bit 1 then 0.

Source files
------------

// File: rtl/reduce_nway_pipe_if.sv
// Handshake bundle for reduce_nway_pipe: input beat side and result side.
// in_last exists only when REDUCE_ACCUM_EN is defined.
interface reduce_nway_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
`ifdef REDUCE_ACCUM_EN
  logic             in_last;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;

`ifdef REDUCE_ACCUM_EN
  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_bit
  );
  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_bit
  );
`else
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_bit
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_bit
  );
`endif
endinterface

// File: rtl/reduce_nway_pipe.sv
// Pipelined WIDTH-input OR/AND/XOR reduction tree with valid/ready handshake.
// Define REDUCE_ACCUM_EN to reduce multi-beat frames (in_last) into one result.
module reduce_nway_pipe #(
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 1
) (
  input logic              clk,
  input logic              reset,
  reduce_nway_pipe_if.slave bus
);

  localparam int LEVELS  = $clog2(WIDTH);
  localparam int PW      = 1 << LEVELS;
  localparam int LATENCY = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  typedef struct packed {
    logic [1:0] mode;
`ifdef REDUCE_ACCUM_EN
    logic       first;
    logic       last;
`endif
  } meta_t;

  // Mode 2'b11 is reserved and behaves as OR.
  function automatic logic op2(input logic [1:0] mode, input logic a, input logic b);
    case (mode)
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  logic          advance;
  logic          accept;
  logic          out_valid;
  logic          out_bit;
  meta_t         in_meta;
  logic [PW-1:0] padded;
  logic          pad_bit;

  assign advance       = !out_valid || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;

`ifdef REDUCE_ACCUM_EN
  logic       first_q;
  logic [1:0] frame_mode_q;

  // The frame's mode is latched from its first beat; later beats reuse it.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q      <= 1'b1;
      frame_mode_q <= 2'b00;
    end else if (accept) begin
      first_q <= bus.in_last;
      if (first_q) frame_mode_q <= bus.in_mode;
    end
  end

  always_comb begin
    in_meta       = '0;
    in_meta.mode  = first_q ? bus.in_mode : frame_mode_q;
    in_meta.first = first_q;
    in_meta.last  = bus.in_last;
  end
`else
  assign in_meta.mode = bus.in_mode;
`endif

  // Unused upper leaves take the identity element of the operation.
  assign pad_bit = (in_meta.mode == 2'b01);

  always_comb begin
    padded              = {PW{pad_bit}};
    padded[WIDTH-1:0]   = bus.in_data;
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int LV_LO = s * REG_EVERY;
    localparam int LV_HI = ((s + 1) * REG_EVERY < LEVELS) ? (s + 1) * REG_EVERY : LEVELS;
    localparam int IN_W  = PW >> LV_LO;
    localparam int OUT_W = PW >> LV_HI;

    logic [IN_W-1:0]  din;
    logic             vin;
    meta_t            mi;
    logic [IN_W-1:0]  work;
    logic [OUT_W-1:0] red;
    logic [OUT_W-1:0] data_q;
    logic             valid_q;

    if (s == 0) begin : g_src
      assign din = padded;
      assign vin = accept;
      assign mi  = in_meta;
    end else begin : g_src
      assign din = g_stage[s-1].data_q;
      assign vin = g_stage[s-1].valid_q;
      assign mi  = g_stage[s-1].g_meta.meta_q;
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred and in-place updates read
    // the freshly computed values.
    always_comb begin
      work = din;
      for (int l = 0; l < LV_HI - LV_LO; l++) begin
        for (int i = 0; i < IN_W / 2; i++) begin
          if (i < (IN_W >> (l + 1))) work[i] = op2(mi.mode, work[2*i], work[2*i+1]);
        end
      end
    end

    assign red = work[OUT_W-1:0];

    if (s == LATENCY - 1) begin : g_out
      logic             vnext;
      logic [OUT_W-1:0] nxt;

`ifdef REDUCE_ACCUM_EN
      logic acc_q;

      assign nxt   = mi.first ? red[0] : op2(mi.mode, acc_q, red[0]);
      assign vnext = vin && mi.last;

      always_ff @(posedge clk) begin
        if (reset) acc_q <= 1'b0;
        else if (advance && vin) acc_q <= nxt[0];
      end
`else
      assign nxt   = red;
      assign vnext = vin;
`endif

      // out_bit only changes when a result is presented, so it holds while idle.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (advance) begin
          valid_q <= vnext;
          if (vnext) data_q <= nxt;
        end
      end

      assign out_valid = valid_q;
      assign out_bit   = data_q[0];
    end else begin : g_meta
      meta_t meta_q;

      always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else if (advance) valid_q <= vin;
      end

      // NOTE: interior datapath registers carry no reset; their contents are
      // qualified by valid_q, which is the only state that must clear.
      always_ff @(posedge clk) begin
        if (advance && vin) begin
          data_q <= red;
          meta_q <= mi;
        end
      end
    end
  end

endmodule
